// File: rtl/gate_check_pkg.sv
// Shared definitions for gate_vector_checker.
// Contents:
//   state_t      - checker FSM states
//   NUM_VECTORS  - number of input combinations applied per run
//   NIB_*        - bit positions of each gate output in the observed nibble
//   EXP_TABLE    - ideal {Nand,And,Or,Nor} nibble per vector index {Up,Bottom}
package gate_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int IDX_W       = 2;
    localparam int NIB_W       = 4;
    localparam int ERR_W       = 3;
    localparam int TMR_W       = 4;

    // Nibble bit order, MSB first: {Nand, And, Or, Nor}
    localparam int NIB_NAND = 3;
    localparam int NIB_AND  = 2;
    localparam int NIB_OR   = 1;
    localparam int NIB_NOR  = 0;

    // Entry [i] is the ideal nibble when {Up,Bottom} == i.
    localparam logic [NUM_VECTORS-1:0][NIB_W-1:0] EXP_TABLE = {
        4'b0110,    // 11
        4'b1010,    // 10
        4'b1010,    // 01
        4'b1001     // 00
    };

    function automatic logic [NIB_W-1:0] expected_nibble(input logic [IDX_W-1:0] idx);
        return EXP_TABLE[idx];
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times the settle window after a vector is driven.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high clear
//   load    - load counter with value (takes priority over counting)
//   value   - count to load
//   expired - high while the counter holds 1, i.e. on the last settle cycle
module settle_timer
    import gate_check_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] value,
    output logic             expired
);

    logic [TMR_W-1:0] r_count;

    // Free-runs down to zero and parks there; the FSM only looks at
    // expired while it is in SETTLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == TMR_W'(1));

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive self-test for a two-input gate block. Applies the four operand
// combinations in order, samples {OutNand,OutAnd,OutOr,OutNor} after a settle
// window and reports pass/fail, mismatch count and the first failing vector.
// Parameters:
//   SETTLE_CYCLES - cycles between driving a vector and sampling (1..15)
//   LOOP          - nonzero: restart automatically after each Done
// Ports:
//   clk, reset          - clock / asynchronous active-high reset
//   Start               - run request, only honoured when idle
//   InputUp/InputBottom - operands to the gate block (vector index bits 1/0)
//   OutNand..OutNor     - gate outputs under test
//   Busy, Done          - run in progress / one-cycle end-of-run pulse
//   Pass, ErrCount      - last run clean / mismatching vectors in run
//   FailVector          - index of first mismatching vector
//   FailObserved        - nibble observed at the first mismatch
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOP          = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    output logic             InputUp,
    output logic             InputBottom,
    input  logic             OutNand,
    input  logic             OutAnd,
    input  logic             OutOr,
    input  logic             OutNor,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [ERR_W-1:0] ErrCount,
    output logic [IDX_W-1:0] FailVector,
    output logic [NIB_W-1:0] FailObserved
);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_up;
    logic             r_bot;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [IDX_W-1:0] r_fvec;
    logic [NIB_W-1:0] r_fobs;

    logic             w_expired;
    logic             w_start;
    logic [NIB_W-1:0] w_obs;
    logic             w_mismatch;

    assign w_obs[NIB_NAND] = OutNand;
    assign w_obs[NIB_AND]  = OutAnd;
    assign w_obs[NIB_OR]   = OutOr;
    assign w_obs[NIB_NOR]  = OutNor;

    assign w_mismatch = (w_obs != expected_nibble(r_idx));

    // A run begins either from an idle Start or straight out of DONE when
    // looping; both paths share the same initialisation.
    assign w_start = ((r_state == ST_IDLE) && Start) ||
                     ((r_state == ST_DONE) && (LOOP != 0));

    settle_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (r_state == ST_DRIVE),
        .value   (TMR_W'(SETTLE_CYCLES)),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_up    <= 1'b0;
            r_bot   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fvec  <= '0;
            r_fobs  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                // Pass is left alone: it reports the last completed run.
                r_state <= ST_DRIVE;
                r_idx   <= '0;
                r_err   <= '0;
                r_fvec  <= '0;
                r_fobs  <= '0;
                r_busy  <= 1'b1;
            end else begin
                unique case (r_state)
                    ST_IDLE: ;
                    ST_DRIVE: begin
                        r_up    <= r_idx[1];
                        r_bot   <= r_idx[0];
                        r_state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (w_expired) r_state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (w_mismatch) begin
                            r_err <= r_err + 1'b1;
                            if (r_err == '0) begin
                                r_fvec <= r_idx;
                                r_fobs <= w_obs;
                            end
                        end
                        if (r_idx == IDX_W'(NUM_VECTORS - 1)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            // r_err has not absorbed this vector yet
                            r_pass  <= (r_err == '0) && !w_mismatch;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_DRIVE;
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign InputUp      = r_up;
    assign InputBottom  = r_bot;
    assign Busy         = r_busy;
    assign Done         = r_done;
    assign Pass         = r_pass;
    assign ErrCount     = r_err;
    assign FailVector   = r_fvec;
    assign FailObserved = r_fobs;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker. Four instances: dut0 (defaults, driven by a
// fault-injectable gate model), dut1 (LOOP=1, SETTLE_CYCLES=1), dut2/dut3
// (gate model with 3-cycle output lag, SETTLE_CYCLES 2 and 4).
module tb_gate_vector_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Truth table written out as listed for the gate block
    logic [3:0] SPEC_TBL [4] = '{4'b1001, 4'b1010, 4'b1010, 4'b0110};

    // Behavioural gate: {nand, and, or, nor}
    function automatic logic [3:0] gate(input logic [1:0] ab);
        logic a, b;
        a = ab[1];
        b = ab[0];
        return {~(a & b), a & b, a | b, ~(a | b)};
    endfunction

    // ---------------- dut0: default parameters, fault injection ----------
    logic       st0, up0, bot0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [1:0] fv0;
    logic [3:0] fo0, g0;
    logic [3:0] mask0 [4];
    logic       stuck_and0;

    always_comb begin
        g0 = gate({up0, bot0}) ^ mask0[{up0, bot0}];
        if (stuck_and0) g0[2] = 1'b1;
    end

    gate_vector_checker dut0 (
        .clk(clk), .reset(reset), .Start(st0),
        .InputUp(up0), .InputBottom(bot0),
        .OutNand(g0[3]), .OutAnd(g0[2]), .OutOr(g0[1]), .OutNor(g0[0]),
        .Busy(busy0), .Done(done0), .Pass(pass0), .ErrCount(err0),
        .FailVector(fv0), .FailObserved(fo0)
    );

    // ---------------- dut1: LOOP=1, SETTLE_CYCLES=1 ----------------------
    logic       st1, up1, bot1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [1:0] fv1;
    logic [3:0] fo1, g1;
    assign g1 = gate({up1, bot1});

    gate_vector_checker #(.SETTLE_CYCLES(1), .LOOP(1)) dut1 (
        .clk(clk), .reset(reset), .Start(st1),
        .InputUp(up1), .InputBottom(bot1),
        .OutNand(g1[3]), .OutAnd(g1[2]), .OutOr(g1[1]), .OutNor(g1[0]),
        .Busy(busy1), .Done(done1), .Pass(pass1), .ErrCount(err1),
        .FailVector(fv1), .FailObserved(fo1)
    );

    // ---------------- dut2/dut3: gate with 3-cycle output lag ------------
    logic       st2, up2, bot2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [1:0] fv2;
    logic [3:0] fo2, d2a, d2b, d2c;
    logic       st3, up3, bot3, busy3, done3, pass3;
    logic [2:0] err3;
    logic [1:0] fv3;
    logic [3:0] fo3, d3a, d3b, d3c;

    always @(posedge clk) begin
        d2a <= gate({up2, bot2}); d2b <= d2a; d2c <= d2b;
        d3a <= gate({up3, bot3}); d3b <= d3a; d3c <= d3b;
    end

    gate_vector_checker #(.SETTLE_CYCLES(2), .LOOP(0)) dut2 (
        .clk(clk), .reset(reset), .Start(st2),
        .InputUp(up2), .InputBottom(bot2),
        .OutNand(d2c[3]), .OutAnd(d2c[2]), .OutOr(d2c[1]), .OutNor(d2c[0]),
        .Busy(busy2), .Done(done2), .Pass(pass2), .ErrCount(err2),
        .FailVector(fv2), .FailObserved(fo2)
    );

    gate_vector_checker #(.SETTLE_CYCLES(4), .LOOP(0)) dut3 (
        .clk(clk), .reset(reset), .Start(st3),
        .InputUp(up3), .InputBottom(bot3),
        .OutNand(d3c[3]), .OutAnd(d3c[2]), .OutOr(d3c[1]), .OutNor(d3c[0]),
        .Busy(busy3), .Done(done3), .Pass(pass3), .ErrCount(err3),
        .FailVector(fv3), .FailObserved(fo3)
    );

    // ---------------- reference model ------------------------------------
    // Given the nibble the gate will present for each vector, derive the
    // run summary the checker must report.
    task automatic model(input logic [3:0][3:0] obs, output logic [2:0] e,
                         output logic [1:0] fv, output logic [3:0] fo, output logic ps);
        e = 0; fv = 0; fo = 0;
        for (int v = 0; v < 4; v++) begin
            if (obs[v] != SPEC_TBL[v]) begin
                if (e == 0) begin
                    fv = 2'(v);
                    fo = obs[v];
                end
                e++;
            end
        end
        ps = (e == 0);
    endtask

    function automatic logic [3:0][3:0] dut0_obs();
        logic [3:0][3:0] o;
        for (int v = 0; v < 4; v++) begin
            o[v] = gate(2'(v)) ^ mask0[v];
            if (stuck_and0) o[v][2] = 1'b1;
        end
        return o;
    endfunction

    // Lagging gate: the sample sees this vector only if the window since the
    // drive edge covers the lag, otherwise it still sees the previous operands
    // (00 before the first vector, left there by reset).
    function automatic logic [3:0][3:0] lag_obs(input int settle, input int lag);
        logic [3:0][3:0] o;
        for (int v = 0; v < 4; v++)
            o[v] = (settle >= lag) ? gate(2'(v)) : gate(2'((v == 0) ? 0 : v - 1));
        return o;
    endfunction

    // One run of dut0 with the currently configured gate faults.
    task automatic run0(input string tag, input bit restart);
        int         per = 4;           // DRIVE + 2 SETTLE + CHECK
        int         len = 16;
        int         done_at = -1;
        int         ndone = 0;
        int         busy_bad = 0;
        logic [2:0] e;
        logic [1:0] fv;
        logic [3:0] fo;
        logic       ps;
        model(dut0_obs(), e, fv, fo, ps);
        @(negedge clk); st0 = 1'b1;
        @(negedge clk); st0 = 1'b0;
        if (!busy0) busy_bad++;
        for (int c = 1; c <= len + 3; c++) begin
            @(negedge clk);
            if ((c - 1) % per == 0 && (c - 1) / per < 4)
                chk({tag, "_ops"}, {30'd0, up0, bot0}, (c - 1) / per);
            if (done0) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (busy0 != (c < len)) busy_bad++;
            st0 = (restart && c == 5);
        end
        chk({tag, "_done_at"}, done_at, len);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_busy"}, busy_bad, 0);
        chk({tag, "_err"}, err0, e);
        chk({tag, "_fv"}, fv0, fv);
        chk({tag, "_fo"}, fo0, fo);
        chk({tag, "_pass"}, pass0, ps);
    endtask

    initial begin
        int q1[$];
        int busy_bad;
        int d2_at, d3_at, nd;
        logic [2:0] e;
        logic [1:0] fv;
        logic [3:0] fo;
        logic       ps;

        reset = 1'b1;
        st0 = 0; st1 = 0; st2 = 0; st3 = 0;
        stuck_and0 = 0;
        for (int v = 0; v < 4; v++) mask0[v] = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {up0, bot0, busy0, done0, pass0, err0, fv0, fo0}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", {up0, bot0, busy0, done0, pass0, err0, fv0, fo0}, 0);

        // Clean gate
        run0("clean", 1'b0);
        chk("clean_pass_const", pass0, 1);

        // AND stuck high
        stuck_and0 = 1'b1;
        run0("stuck", 1'b0);
        chk("stuck_const", {err0, fv0, fo0}, {3'd3, 2'b00, 4'b1101});

        // Start re-pulsed mid-run is ignored
        run0("restart", 1'b1);
        stuck_and0 = 1'b0;

        // Random fault patterns
        for (int r = 0; r < 6; r++) begin
            for (int v = 0; v < 4; v++)
                mask0[v] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            run0("rand", 1'b0);
        end
        for (int v = 0; v < 4; v++) mask0[v] = 4'd0;

        // LOOP=1, SETTLE_CYCLES=1: period 13, Busy low only in the DONE cycle
        busy_bad = 0;
        @(negedge clk); st1 = 1'b1;
        @(negedge clk); st1 = 1'b0;
        if (!busy1) busy_bad++;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done1) q1.push_back(c);
            if (busy1 == done1) busy_bad++;
        end
        chk("loop_ndone", q1.size(), 3);
        chk("loop_first", (q1.size() > 0) ? q1[0] : -1, 12);
        chk("loop_gap1", (q1.size() > 1) ? q1[1] - q1[0] : -1, 13);
        chk("loop_gap2", (q1.size() > 2) ? q1[2] - q1[1] : -1, 13);
        chk("loop_busy", busy_bad, 0);
        chk("loop_pass", pass1, 1);

        // Lagging gate: too-short settle versus adequate settle
        d2_at = -1; d3_at = -1;
        @(negedge clk); st2 = 1'b1; st3 = 1'b1;
        @(negedge clk); st2 = 1'b0; st3 = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done2 && d2_at < 0) d2_at = c;
            if (done3 && d3_at < 0) d3_at = c;
        end
        chk("lag2_done_at", d2_at, 16);
        chk("lag4_done_at", d3_at, 24);
        model(lag_obs(2, 3), e, fv, fo, ps);
        chk("lag2_res", {pass2, err2, fv2, fo2}, {ps, e, fv, fo});
        model(lag_obs(4, 3), e, fv, fo, ps);
        chk("lag4_res", {pass3, err3, fv3, fo3}, {ps, e, fv, fo});
        chk("lag4_pass", pass3, 1);

        // Reset mid-run aborts with no Done
        stuck_and0 = 1'b1;
        @(negedge clk); st0 = 1'b1;
        @(negedge clk); st0 = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_err_before_rst", err0, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_outs", {up0, bot0, busy0, done0, pass0, err0, fv0, fo0}, 0);
        @(negedge clk); reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done0) nd++;
        end
        chk("mid_no_done", nd, 0);
        chk("mid_idle_busy", busy0, 0);

        // Fresh run after abort
        stuck_and0 = 1'b0;
        run0("fresh", 1'b0);
        chk("fresh_pass", pass0, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
